// File: rtl/multicycle_control.sv
// Control FSM for the shared multicycle datapath: sequences fetch, decode
// and per-opcode execute steps, stalling on memory ready with a timeout trap.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op_code,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state,
   output logic       trap
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;
   localparam logic [3:0] S_TRAP   = 4'd13;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] TO_MAX = '1;
   localparam bit              TO_EN  = (MEM_TIMEOUT != 0);

   logic [3:0]      cur;
   logic [3:0]      nxt;
   logic [TO_W-1:0] wcnt;
   logic [TO_W-1:0] wcnt_nxt;
   logic            waiting;
   logic            timeout;

   // Branch resolution happens in the datapath (zero AND PCWriteCond).
   logic unused_zero;
   assign unused_zero = zero;

   assign state = cur;
   assign trap  = (cur == S_TRAP);

   always_comb begin
      waiting = ((cur == S_FETCH) || (cur == S_MEMRD) ||
                 (cur == S_MEMWR)) && !mem_ready;
      timeout = TO_EN && waiting && (wcnt == TO_LIM);
   end

   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_IDLE:   nxt = S_FETCH;
         S_FETCH: begin
            if (timeout)        nxt = S_TRAP;
            else if (mem_ready) nxt = S_DECODE;
            else                nxt = S_FETCH;
         end
         S_DECODE: begin
            case (Op_code)
               OP_R:         nxt = S_EXEC;
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_BEQ:       nxt = S_BRANCH;
               OP_ADDI:      nxt = S_ADDIEX;
               OP_J:         nxt = S_JUMP;
               default:      nxt = S_TRAP;
            endcase
         end
         S_MEMADR: nxt = (Op_code == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (timeout)        nxt = S_TRAP;
            else if (mem_ready) nxt = S_MEMWB;
            else                nxt = S_MEMRD;
         end
         S_MEMWR: begin
            if (timeout)        nxt = S_TRAP;
            else if (mem_ready) nxt = S_FETCH;
            else                nxt = S_MEMWR;
         end
         S_EXEC:   nxt = S_ALUWB;
         S_ADDIEX: nxt = S_ADDIWB;
         S_TRAP:   nxt = S_TRAP;
         default:  nxt = S_FETCH;
      endcase
   end

   // A stalled state never changes, so clearing on !waiting covers exits.
   always_comb begin
      wcnt_nxt = '0;
      if (waiting && !timeout)
         wcnt_nxt = (wcnt == TO_MAX) ? wcnt : wcnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur  <= S_IDLE;
         wcnt <= '0;
      end else begin
         cur  <= nxt;
         wcnt <= wcnt_nxt;
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      case (cur)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table, corner sequences and
// random instruction streams checked against an instruction-plan model.
module tb_multicycle_control;

   localparam int TMO = 15;

   localparam int B_PCW  = 16;
   localparam int B_PCWC = 15;
   localparam int B_IORD = 14;
   localparam int B_MR   = 13;
   localparam int B_MW   = 12;
   localparam int B_IRW  = 11;
   localparam int B_M2R  = 10;
   localparam int B_RD   = 9;
   localparam int B_RW   = 8;
   localparam int B_SA   = 7;
   localparam int B_TRAP = 0;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] Op_code = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;
   logic       trap;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
      .clk(clk), .reset(reset), .Op_code(Op_code), .zero(zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .trap(trap)
   );

   logic [16:0] act_ctl;
   assign act_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                     IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                     ALUSrcB, ALUOp, PCSource, trap};

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;

   // Model: the step being executed, the remaining steps of the
   // current instruction, and consecutive memory wait cycles.
   int m_s = 0;
   int m_plan[$];
   int m_wait = 0;

   int          last_state;
   logic [16:0] last_ctl;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                    nm, cyc, act, exp);
   endtask

   function automatic logic [16:0] ctl_of(input int s, input bit r);
      logic [16:0] c;
      c = '0;
      case (s)
         1: begin
            c[B_MR] = 1'b1; c[6:5] = 2'b01;
            c[B_PCW] = r; c[B_IRW] = r;
         end
         2: c[6:5] = 2'b11;
         3: begin c[B_SA] = 1'b1; c[6:5] = 2'b10; end
         4: begin c[B_MR] = 1'b1; c[B_IORD] = 1'b1; end
         5: begin c[B_RW] = 1'b1; c[B_M2R] = 1'b1; end
         6: begin c[B_MW] = 1'b1; c[B_IORD] = 1'b1; end
         7: begin c[B_SA] = 1'b1; c[4:3] = 2'b10; end
         8: begin c[B_RW] = 1'b1; c[B_RD] = 1'b1; end
         9: begin
            c[B_SA] = 1'b1; c[4:3] = 2'b01;
            c[B_PCWC] = 1'b1; c[2:1] = 2'b01;
         end
         10: begin c[B_SA] = 1'b1; c[6:5] = 2'b10; end
         11: c[B_RW] = 1'b1;
         12: begin c[B_PCW] = 1'b1; c[2:1] = 2'b10; end
         13: c[B_TRAP] = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   task automatic m_advance(input bit r, input logic [5:0] op);
      if (m_s == 13) return;
      if ((m_s == 1 || m_s == 4 || m_s == 6) && !r) begin
         if (TMO != 0 && m_wait == TMO) m_s = 13;
         else if (m_wait < 15) m_wait++;
         return;
      end
      m_wait = 0;
      if (m_s == 0) begin
         m_s = 1;
      end else if (m_s == 1) begin
         case (op)
            OP_R:    m_plan = '{2, 7, 8};
            OP_LW:   m_plan = '{2, 3, 4, 5};
            OP_SW:   m_plan = '{2, 3, 6};
            OP_BEQ:  m_plan = '{2, 9};
            OP_ADDI: m_plan = '{2, 10, 11};
            OP_J:    m_plan = '{2, 12};
            default: m_plan = '{2, 13};
         endcase
         m_s = m_plan.pop_front();
      end else if (m_plan.size() > 0) begin
         m_s = m_plan.pop_front();
      end else begin
         m_s = 1;
      end
   endtask

   task automatic m_reset();
      m_s = 0;
      m_wait = 0;
      m_plan.delete();
   endtask

   task automatic tick(input bit r, input logic [5:0] op);
      mem_ready = r;
      Op_code = op;
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      last_state = int'(state);
      last_ctl = act_ctl;
      check("state", int'(state), m_s);
      check("ctl", int'(act_ctl), int'(ctl_of(m_s, r)));
      @(posedge clk);
      cyc++;
      m_advance(r, op);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      Op_code = '0;
      m_reset();
      @(negedge clk);
      check("rst_state", int'(state), 0);
      check("rst_ctl", int'(act_ctl), 0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   typedef struct {
      logic [5:0] op;
      bit         rdy;
      int         st;
      bit         pcw;
      bit         rw;
   } vec_t;

   vec_t tbl [23];

   logic [5:0] legal [6];
   logic [5:0] cur_op;
   bit         rdy;
   int         trap_hold;

   initial begin
      tbl[0]  = '{OP_R,    1'b1, 0,  1'b0, 1'b0};
      tbl[1]  = '{OP_R,    1'b1, 1,  1'b1, 1'b0};
      tbl[2]  = '{OP_R,    1'b1, 2,  1'b0, 1'b0};
      tbl[3]  = '{OP_R,    1'b1, 7,  1'b0, 1'b0};
      tbl[4]  = '{OP_R,    1'b1, 8,  1'b0, 1'b1};
      tbl[5]  = '{OP_LW,   1'b1, 1,  1'b1, 1'b0};
      tbl[6]  = '{OP_LW,   1'b1, 2,  1'b0, 1'b0};
      tbl[7]  = '{OP_LW,   1'b1, 3,  1'b0, 1'b0};
      tbl[8]  = '{OP_LW,   1'b1, 4,  1'b0, 1'b0};
      tbl[9]  = '{OP_LW,   1'b1, 5,  1'b0, 1'b1};
      tbl[10] = '{OP_SW,   1'b1, 1,  1'b1, 1'b0};
      tbl[11] = '{OP_SW,   1'b1, 2,  1'b0, 1'b0};
      tbl[12] = '{OP_SW,   1'b1, 3,  1'b0, 1'b0};
      tbl[13] = '{OP_SW,   1'b1, 6,  1'b0, 1'b0};
      tbl[14] = '{OP_BEQ,  1'b1, 1,  1'b1, 1'b0};
      tbl[15] = '{OP_BEQ,  1'b1, 2,  1'b0, 1'b0};
      tbl[16] = '{OP_BEQ,  1'b1, 9,  1'b0, 1'b0};
      tbl[17] = '{OP_J,    1'b1, 1,  1'b1, 1'b0};
      tbl[18] = '{OP_J,    1'b1, 2,  1'b0, 1'b0};
      tbl[19] = '{OP_J,    1'b1, 12, 1'b1, 1'b0};
      tbl[20] = '{OP_ADDI, 1'b1, 1,  1'b1, 1'b0};
      tbl[21] = '{OP_ADDI, 1'b1, 2,  1'b0, 1'b0};
      tbl[22] = '{OP_ADDI, 1'b1, 10, 1'b0, 1'b0};
      legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

      do_reset();
      for (int i = 0; i < 23; i++) begin
         tick(tbl[i].rdy, tbl[i].op);
         check("tbl_state", last_state, tbl[i].st);
         check("tbl_pcw", int'(last_ctl[B_PCW]), int'(tbl[i].pcw));
         check("tbl_rw", int'(last_ctl[B_RW]), int'(tbl[i].rw));
      end
      tick(1'b1, OP_ADDI);
      check("addiwb", last_state, 11);
      check("addiwb_rw", int'(last_ctl[B_RW]), 1);

      // lw stalled three cycles in MEMRD
      tick(1'b1, OP_LW);
      tick(1'b1, OP_LW);
      tick(1'b1, OP_LW);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, OP_LW);
         check("lw_wait_st", last_state, 4);
         check("lw_wait_rd", int'(last_ctl[B_MR] & last_ctl[B_IORD]), 1);
      end
      tick(1'b1, OP_LW);
      check("lw_rdy_st", last_state, 4);
      tick(1'b1, OP_LW);
      check("lw_wb_st", last_state, 5);
      check("lw_wb_m2r", int'(last_ctl[B_M2R]), 1);

      // beq: one BRANCH cycle then back to FETCH
      tick(1'b1, OP_BEQ);
      tick(1'b1, OP_BEQ);
      tick(1'b1, OP_BEQ);
      check("beq_st", last_state, 9);
      check("beq_pcwc", int'(last_ctl[B_PCWC]), 1);
      check("beq_aluop", int'(last_ctl[4:3]), 1);
      check("beq_pcsrc", int'(last_ctl[2:1]), 1);
      tick(1'b1, OP_R);
      check("beq_after", last_state, 1);
      check("beq_after_pcwc", int'(last_ctl[B_PCWC]), 0);
      tick(1'b1, OP_R);
      tick(1'b1, OP_R);
      tick(1'b1, OP_R);

      // ready arriving on the timeout cycle completes the fetch
      for (int i = 0; i < TMO; i++) begin
         tick(1'b0, OP_R);
         check("to_wait_irw", int'(last_ctl[B_IRW]), 0);
      end
      tick(1'b1, OP_R);
      check("to_rdy_irw", int'(last_ctl[B_IRW]), 1);
      tick(1'b1, OP_R);
      check("to_rdy_dec", last_state, 2);
      tick(1'b1, OP_R);
      tick(1'b1, OP_R);

      // fetch never answered -> trap
      for (int i = 0; i <= TMO; i++) tick(1'b0, OP_R);
      tick(1'b0, OP_R);
      check("to_trap_st", last_state, 13);
      for (int i = 0; i < 20; i++) begin
         tick(1'($urandom_range(0, 1)), OP_LW);
         check("to_trap_hold", int'(last_ctl[B_TRAP]), 1);
         check("to_trap_strb", int'(last_ctl[16:1]), 0);
      end
      do_reset();

      // illegal opcode
      tick(1'b1, OP_BAD);
      tick(1'b1, OP_BAD);
      tick(1'b1, OP_BAD);
      for (int i = 0; i < 21; i++) begin
         tick(1'($urandom_range(0, 1)), OP_R);
         check("ill_st", last_state, 13);
         check("ill_trap", int'(trap), 1);
      end
      do_reset();

      // reset asserted while a store waits for memory
      tick(1'b1, OP_SW);
      tick(1'b1, OP_SW);
      tick(1'b1, OP_SW);
      tick(1'b1, OP_SW);
      tick(1'b0, OP_SW);
      check("sw_wait_mw", int'(last_ctl[B_MW]), 1);
      tick(1'b0, OP_SW);
      #2 reset = 1'b1;
      #1;
      check("arst_mw", int'(MemWrite), 0);
      check("arst_st", int'(state), 0);
      check("arst_trap", int'(trap), 0);
      m_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      tick(1'b1, OP_R);
      check("arst_idle", last_state, 0);
      tick(1'b1, OP_R);
      check("arst_fetch", last_state, 1);

      // random instruction streams
      cur_op = OP_R;
      trap_hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (m_s == 13) trap_hold++;
         else trap_hold = 0;
         if (trap_hold >= 3) begin
            do_reset();
            trap_hold = 0;
         end
         if (m_s == 1 || m_s == 0) begin
            if ($urandom_range(0, 29) == 0) cur_op = 6'($urandom);
            else cur_op = legal[$urandom_range(0, 5)];
         end
         if (i >= 2000 && i < 2600) rdy = ($urandom_range(0, 15) == 0);
         else rdy = ($urandom_range(0, 3) != 0);
         tick(rdy, cur_op);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
